// File: rtl/mem_arb.sv
// Single-port memory arbiter: shares one synchronous memory between instruction fetch and
// load/store, with a run limit on back-to-back data grants while a fetch is waiting.
module mem_arb #(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned MAX_RUN = 4
) (
  input  logic          clk,
  input  logic          rst_f,
  // Fetch side
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rdy,
  output logic [DW-1:0] if_rdata,
  // Load/store side
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rdy,
  output logic [DW-1:0] dm_rdata,
  // Memory port
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int unsigned WCW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned RCW = $clog2(MAX_RUN + 1);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } state_e;

  state_e           r_state;
  logic [WCW-1:0]   r_wait_cnt;
  logic [RCW-1:0]   r_run_cnt;
  logic             r_owner_dm;
  logic             r_we;

  logic             w_any_req;
  logic             w_grant_dm;

  // Data wins ties until it has taken MAX_RUN grants in a row past a waiting fetch.
  assign w_any_req  = if_req | dm_req;
  assign w_grant_dm = dm_req & (~if_req | (r_run_cnt != RCW'(MAX_RUN)));

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_state    <= StIdle;
      r_wait_cnt <= '0;
      r_run_cnt  <= '0;
      r_owner_dm <= 1'b0;
      r_we       <= 1'b0;
      if_gnt     <= 1'b0;
      if_rdy     <= 1'b0;
      if_rdata   <= '0;
      dm_gnt     <= 1'b0;
      dm_rdy     <= 1'b0;
      dm_rdata   <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      if_gnt <= 1'b0;
      dm_gnt <= 1'b0;
      if_rdy <= 1'b0;
      dm_rdy <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;

      unique case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_state    <= StIssue;
            busy       <= 1'b1;
            mem_en     <= 1'b1;
            r_owner_dm <= w_grant_dm;
            if (w_grant_dm) begin
              dm_gnt    <= 1'b1;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
              mem_we    <= dm_we;
              r_we      <= dm_we;
              r_run_cnt <= if_req ? r_run_cnt + 1'b1 : '0;
            end else begin
              if_gnt    <= 1'b1;
              mem_addr  <= if_addr;
              r_we      <= 1'b0;
              r_run_cnt <= '0;
            end
          end
        end

        StIssue: begin
          r_state    <= StWait;
          r_wait_cnt <= '0;
        end

        StWait: begin
          if (r_wait_cnt == WCW'(MEM_LAT - 1)) begin
            r_state <= StDone;
            if (r_owner_dm) begin
              dm_rdy <= 1'b1;
              if (!r_we) dm_rdata <= mem_rdata;
            end else begin
              if_rdy   <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end

        StDone: begin
          r_state <= StIdle;
          busy    <= 1'b0;
        end

        default: begin
          r_state <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arb.md
# mem_arb

Single-port memory arbiter for the SISC computer. It shares one synchronous memory port between the instruction-fetch path and the load/store path. Each side sees a simple req/gnt/rdy handshake, and a starvation guard keeps fetch from being locked out by a run of data accesses. It sits between the control unit's fetch/memory-state requests and the unified instruction/data memory.

## Interface
- AW, 16, address width
- DW, 32, data width
- MEM_LAT, 2, memory read latency in cycles (≥1); read data is valid MEM_LAT cycles after the mem_en cycle
- MAX_RUN, 4, maximum consecutive data grants while a fetch is pending (≥1)

- clk  in  1  system clock, positive edge active
- rst_f  in  1  reset; one clock, reset asynchronous and active-low
- if_req  in  1  fetch request; held until if_rdy
- if_addr  in  AW  fetch address; must be stable while if_req is high and not yet granted
- if_gnt  out  1  one-cycle pulse: fetch request accepted
- if_rdy  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DW  fetched word; registered, holds until the next fetch completes
- dm_req  in  1  load/store request; held until dm_rdy
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  AW  data address
- dm_wdata  in  DW  store data
- dm_gnt  out  1  one-cycle pulse: data request accepted
- dm_rdy  out  1  one-cycle pulse: access complete; dm_rdata valid for loads
- dm_rdata  out  DW  load word; registered, unchanged by stores
- mem_en  out  1  memory access strobe, high exactly one cycle per access
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  AW  memory address (latched copy)
- mem_wdata  out  DW  memory write data (latched copy)
- mem_rdata  in  DW  memory read data
- busy  out  1  high whenever state ≠ IDLE

## Operation
- **States:**
  - IDLE → ISSUE when any request is sampled high at a clock edge.
  - ISSUE → WAIT unconditionally.
  - WAIT holds for MEM_LAT cycles, then → DONE.
  - DONE → IDLE unconditionally.
- **Arbitration** happens only at the edge ending an IDLE cycle.
  - Only one request high: grant it.
  - Both high: grant dm, unless run_cnt == MAX_RUN, in which case grant if.
- **Run counter (run_cnt):**
  - A dm grant while if_req is high increments run_cnt.
  - A dm grant with if_req low clears it.
  - An if grant clears it.
  - Reset value is 0. The counter never exceeds MAX_RUN.
- **Grant edge:**
  - Latch the owner, the address, and for dm also we and wdata.
  - The winning gnt is high for the following (ISSUE) cycle only.
- **ISSUE cycle:** mem_en=1, mem_we = latched we (always 0 for fetch), mem_addr/mem_wdata driven from the latches.
- **Data capture:** at the edge ending the last WAIT cycle, mem_rdata is captured into if_rdata (fetch) or dm_rdata (load). Stores capture nothing.
- **DONE cycle:** the owner's rdy=1. No arbitration takes place in DONE. The requester drops or renews req at the edge ending DONE.
- **Request withdrawal:**
  - A request dropped before its grant is simply withdrawn.
  - Once granted, the access completes and rdy pulses even if req falls.
- **Reset (rst_f low, asynchronous, any state including mid-access):**
  - state=IDLE, run_cnt=0.
  - gnt/rdy/mem_en/mem_we/busy = 0.
  - mem_addr, mem_wdata, if_rdata, dm_rdata = 0.
  - An in-flight access is abandoned and no rdy is issued.

## Timing
- All outputs are registered. No combinational path from req to any output.
- **Access timeline**, with req first sampled at the edge ending IDLE cycle 0:
  - gnt and mem_en in cycle 1.
  - mem_rdata valid in cycle 1+MEM_LAT, captured at the end of that cycle.
  - rdy in cycle 2+MEM_LAT.
  - IDLE in cycle 3+MEM_LAT.
- With MEM_LAT=2: rdy in cycle 4. Throughput is one access per MEM_LAT+3 cycles.
- Minimum one IDLE cycle between accesses.
- gnt, mem_en and rdy are each exactly one cycle wide.
- Only one access is outstanding at a time.

## Test plan
- **Reset mid-access:** if_req=1 with if_addr=0x0010, mem returns 0xDEADBEEF; pull rst_f low during WAIT → all outputs 0 immediately, no if_rdy. After release, a fresh request completes normally.
- **Single fetch, MEM_LAT=2:** if_req=1, if_addr=0x0010, mem returns 0xDEADBEEF → if_gnt + mem_en (mem_we=0, mem_addr=0x0010) in cycle 1; if_rdy in cycle 4 with if_rdata=0xDEADBEEF; busy high in cycles 1–4.
- **Store:** dm_req=1, dm_we=1, dm_addr=0x0100, dm_wdata=0x12345678 → mem_en/mem_we=1 with matching addr/data in cycle 1; dm_rdy in cycle 4; dm_rdata unchanged from its prior value.
- **Simultaneous requests:** if_req and dm_req rise together (dm is a load) → dm granted first; after dm_rdy and dm_req dropping, if is granted at the next IDLE edge.
- **Starvation guard (MAX_RUN=4):** if_req held high while dm_req is renewed after every dm_rdy → exactly 4 dm grants, then the if grant; run_cnt=0 after the if grant.
- **Withdrawn and abandoned requests:** dm_req pulsed for one cycle during a busy fetch → never granted. A granted access whose req falls in WAIT still produces rdy in cycle 2+MEM_LAT.
